alu_issue_ctrl: RTL

Initiator side of the 32-bit ALU interface in the MIPS datapath. Accepts one operation request (opcode, funct, two operands), decodes it into the 4-bit ALU select code, and drives the ALU's operand and select inputs. It waits a fixed number of cycles for the registered ALU result, then returns the result, a locally computed zero flag and an error flag through a valid/ready response channel.

---
 rtl/mips_alu_pkg.sv | 34 +++
 rtl/alu_issue_ctrl_if.sv | 31 +++
 rtl/alu_op_decode.sv | 36 +++
 rtl/alu_issue_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared ALU definitions for the MIPS datapath: select codes, opcode/funct values
// and the issue-control state type.
package mips_alu_pkg;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response signals of the ALU issue controller.
// master = requester/ALU environment, slave = the controller.
interface alu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_first;
    logic [31:0] alu_second;
    logic [3:0]  alu_select;
    logic [31:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;

    modport master (
        output req_valid, req_opcode, req_funct, req_a, req_b, alu_out, rsp_ready,
        input  req_ready, alu_first, alu_second, alu_select,
        input  rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_opcode, req_funct, req_a, req_b, alu_out, rsp_ready,
        output req_ready, alu_first, alu_second, alu_select,
        output rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct to ALU select decode with an illegal-op flag.
module alu_op_decode
    import mips_alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] select,
    output logic       illegal
);

    always_comb begin
        select  = SEL_AND;
        illegal = 1'b0;
        if (opcode == OP_RTYPE) begin
            unique case (funct)
                FN_ADD:  select = SEL_ADD;
                FN_SUB:  select = SEL_SUB;
                FN_AND:  select = SEL_AND;
                FN_OR:   select = SEL_OR;
                FN_NOR:  select = SEL_NOR;
                FN_SLT:  select = SEL_SLT;
                default: illegal = 1'b1;
            endcase
        end else begin
            unique case (opcode)
                OP_ADDI, OP_LW, OP_SW: select = SEL_ADD;
                OP_ANDI:               select = SEL_AND;
                OP_ORI:                select = SEL_OR;
                OP_SLTI:               select = SEL_SLT;
                OP_BEQ:                select = SEL_SUB;
                default:               illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded operation to a registered ALU, waits ALU_LATENCY edges,
// then returns result/zero/error on a valid/ready response channel.
module alu_issue_ctrl
    import mips_alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1
)
(
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus
);

    localparam logic [3:0] LAT = 4'(ALU_LATENCY);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] first_reg, first_next;
    logic [31:0] second_reg, second_next;
    logic [3:0]  select_reg, select_next;
    logic [31:0] result_reg, result_next;
    logic        zero_reg, zero_next;
    logic        err_reg, err_next;

    logic [3:0]  dec_select;
    logic        dec_illegal;

    alu_op_decode u_decode (
        .opcode  (bus.req_opcode),
        .funct   (bus.req_funct),
        .select  (dec_select),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 4'd0;
            first_reg  <= 32'd0;
            second_reg <= 32'd0;
            select_reg <= SEL_AND;
            result_reg <= 32'd0;
            zero_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            first_reg  <= first_next;
            second_reg <= second_next;
            select_reg <= select_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        first_next  = first_reg;
        second_next = second_reg;
        select_next = select_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        err_next    = err_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    // Illegal ops never touch the ALU operands; they answer directly.
                    if (dec_illegal) begin
                        err_next    = 1'b1;
                        result_next = 32'd0;
                        zero_next   = 1'b0;
                        state_next  = ST_RESP;
                    end else begin
                        first_next  = bus.req_a;
                        second_next = bus.req_b;
                        select_next = dec_select;
                        cnt_next    = LAT;
                        state_next  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    result_next = bus.alu_out;
                    zero_next   = (bus.alu_out == 32'd0);
                    err_next    = 1'b0;
                    state_next  = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.req_ready  = (state_reg == ST_IDLE);
    assign bus.rsp_valid  = (state_reg == ST_RESP);
    assign bus.alu_first  = first_reg;
    assign bus.alu_second = second_reg;
    assign bus.alu_select = select_reg;
    assign bus.rsp_result = result_reg;
    assign bus.rsp_zero   = zero_reg;
    assign bus.rsp_err    = err_reg;

endmodule
